// File: rtl/rv32_bus_pkg.sv
// rv32_bus_pkg: shared FSM states, request struct and widths for the rv32 data bus
package rv32_bus_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W = WORD_W / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef struct packed {
    logic we;
    logic [WORD_W-1:0] addr;
    logic [BE_W-1:0] be;
    logic [WORD_W-1:0] wdata;
  } bus_req_t;
endpackage

// File: rtl/rv32_sp_ram_be.sv
// rv32_sp_ram_be: single-port synchronous RAM, byte-masked write or registered read per cycle
module rv32_sp_ram_be
  import rv32_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WIDTH = WORD_W
) (
  input  logic                           clk,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [WIDTH/8-1:0]             be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [WIDTH-1:0]               wdata_i,
  output logic [WIDTH-1:0]               rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int i = 0; i < WIDTH / 8; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/rv32_dmem_responder.sv
// rv32_dmem_responder: data RAM responder with programmable wait states and one-cycle response strobe
module rv32_dmem_responder
  import rv32_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk_sys_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0] CNT_INIT = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
  bus_req_t req;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d, idx_in, cur_idx;
  logic [WORD_W-1:0] off, ram_rdata;
  logic we_q, we_d, fault_q, fault_d, zero_q, zero_d, err_q, err_d;
  logic acc, fault_in, enter_resp, cur_we, cur_fault, ram_en;
  assign req = '{we: we_i, addr: addr_i, be: be_i, wdata: wdata_i};
  assign off = req.addr - BASE_ADDR;
  assign idx_in = off[AW+1:2];
  assign fault_in = (req.addr < BASE_ADDR) || (off >= SPAN);
  assign gnt_o = state_q != WAIT;
  assign acc = req_i && gnt_o;
  assign rvalid_o = state_q == RESP;
  assign rdata_o = zero_q ? '0 : ram_rdata;
  assign err_o = err_q;
  always_comb begin
    cur_we = acc ? req.we : we_q;
    cur_fault = acc ? fault_in : fault_q;
    cur_idx = acc ? idx_in : idx_q;
    enter_resp = (acc && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);
    ram_en = (acc && req.we && !fault_in) || (enter_resp && !cur_we && !cur_fault);
    state_d = acc ? (WAIT_CYCLES > 0 ? WAIT : RESP) : (state_q == WAIT ? (cnt_q == 4'd0 ? RESP : WAIT) : IDLE);
    cnt_d = acc ? CNT_INIT : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    we_d = cur_we;
    fault_d = cur_fault;
    idx_d = cur_idx;
    zero_d = enter_resp ? (cur_we || cur_fault) : zero_q;
    err_d = enter_resp ? cur_fault : err_q;
  end
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      we_q <= 1'b0;
      fault_q <= 1'b0;
      zero_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      we_q <= we_d;
      fault_q <= fault_d;
      zero_q <= zero_d;
      err_q <= err_d;
    end
  end
  rv32_sp_ram_be #(.DEPTH_WORDS(DEPTH_WORDS), .WIDTH(WORD_W)) u_ram (
    .clk(clk_sys_i),
    .en_i(ram_en),
    .we_i(acc && req.we),
    .be_i(req.be),
    .addr_i(cur_idx),
    .wdata_i(req.wdata),
    .rdata_o(ram_rdata)
  );
endmodule

// File: tb/tb_rv32_dmem_responder.sv
// tb_rv32_dmem_responder: randomized and directed checks of three responders (1, 0 and 3 wait states) against a word-array model
module tb_rv32_dmem_responder;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  logic rst_n;
  logic req [3];
  logic we [3];
  logic [31:0] addr [3];
  logic [3:0] be [3];
  logic [31:0] wdata [3];
  logic gnt [3];
  logic rvalid [3];
  logic [31:0] rdata [3];
  logic err [3];
  logic [31:0] mdl [3][DEPTH];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) u0 (
    .clk_sys_i(clk), .rst_n_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]), .be_i(be[0]),
    .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));
  rv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u1 (
    .clk_sys_i(clk), .rst_n_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]), .be_i(be[1]),
    .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));
  rv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u2 (
    .clk_sys_i(clk), .rst_n_i(rst_n), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]), .be_i(be[2]),
    .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));
  function automatic int wc(input int k);
    return k == 0 ? 1 : (k == 1 ? 0 : 3);
  endfunction
  function automatic bit is_fault(input logic [31:0] a);
    return longint'(a) < longint'(BASE) || longint'(a) >= longint'(BASE) + 4 * DEPTH;
  endfunction
  function automatic logic [31:0] rand_addr();
    int r = int'($urandom % 8);
    if (r < 5) return BASE + 4 * ($urandom % 8) + ($urandom % 4);
    if (r == 5) return BASE - 1 - ($urandom % 64);
    if (r == 6) return BASE + 4 * DEPTH - 4 + ($urandom % 4);
    return ($urandom % 2) ? BASE + 4 * DEPTH + ($urandom % 64) : ($urandom | 32'h8000_0000);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model(input int k, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] er, output logic ee);
    int i;
    ee = is_fault(a);
    er = 32'h0;
    if (!ee) begin
      i = int'((a - BASE) / 4);
      if (w) begin
        for (int j = 0; j < 4; j++) if (b[j]) mdl[k][i][8*j +: 8] = d[8*j +: 8];
      end else er = mdl[k][i];
    end
  endtask
  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input string tag);
    logic [31:0] er;
    logic ee;
    int n;
    model(k, w, a, b, d, er, ee);
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    chk($sformatf("%s_gnt", tag), {31'b0, gnt[k]}, 32'd1);
    @(posedge clk);
    #1;
    req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom; be[k] = 4'($urandom); wdata[k] = $urandom;
    n = 0;
    @(negedge clk);
    while (!rvalid[k] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("%s_lat", tag), 32'(n), 32'(wc(k)));
    chk($sformatf("%s_rdata", tag), rdata[k], er);
    chk($sformatf("%s_err", tag), {31'b0, err[k]}, {31'b0, ee});
    @(negedge clk);
    chk($sformatf("%s_pulse", tag), {31'b0, rvalid[k]}, 32'd0);
    chk($sformatf("%s_hold", tag), rdata[k], er);
  endtask
  task automatic chk_idle(input int k, input string tag);
    chk($sformatf("%s_gnt", tag), {31'b0, gnt[k]}, 32'd1);
    chk($sformatf("%s_rvalid", tag), {31'b0, rvalid[k]}, 32'd0);
    chk($sformatf("%s_rdata", tag), rdata[k], 32'd0);
    chk($sformatf("%s_err", tag), {31'b0, err[k]}, 32'd0);
  endtask
  initial begin
    logic [31:0] er;
    logic ee;
    logic [31:0] exp_d [5];
    logic exp_e [5];
    int seen;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_idle(k, $sformatf("reset%0d", k));
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 9; w++)
        txn(k, 1'b1, BASE + 4 * (w == 8 ? DEPTH - 1 : w), 4'hF, $urandom, "preload");
    txn(0, 1'b1, 32'h2000, 4'hF, 32'hDEAD_BEEF, "store_deadbeef");
    txn(0, 1'b0, 32'h2000, 4'h0, 32'h0, "load_deadbeef");
    chk("load_deadbeef_const", rdata[0], 32'hDEAD_BEEF);
    txn(0, 1'b1, 32'h2004, 4'hF, 32'h0000_00AA, "store_aa");
    txn(0, 1'b1, 32'h2004, 4'b0100, 32'h1122_3344, "store_merge");
    txn(0, 1'b0, 32'h2004, 4'h3, 32'h0, "load_merge");
    chk("load_merge_const", rdata[0], 32'h0022_00AA);
    txn(0, 1'b0, 32'h1FFC, 4'hF, 32'h0, "fault_low");
    chk("fault_low_err", {31'b0, err[0]}, 32'd1);
    txn(0, 1'b0, BASE + 4 * DEPTH, 4'hF, 32'h0, "fault_high");
    chk("fault_high_err", {31'b0, err[0]}, 32'd1);
    txn(0, 1'b1, 32'h1FFC, 4'hF, 32'hFFFF_FFFF, "fault_store");
    txn(0, 1'b1, BASE + 4 * DEPTH, 4'hF, 32'hFFFF_FFFF, "fault_store_hi");
    txn(0, 1'b0, 32'h2000, 4'hF, 32'h0, "adjacent_low");
    chk("adjacent_low_const", rdata[0], 32'hDEAD_BEEF);
    txn(0, 1'b0, BASE + 4 * DEPTH - 4, 4'hF, 32'h0, "adjacent_high");
    txn(0, 1'b1, 32'h2000, 4'h0, 32'h1234_5678, "store_be0");
    txn(0, 1'b0, 32'h2000, 4'hF, 32'h0, "load_be0");
    chk("load_be0_const", rdata[0], 32'hDEAD_BEEF);
    model(1, 1'b1, BASE + 20, 4'hF, 32'hCAFE_F00D, exp_d[0], exp_e[0]);
    for (int i = 1; i < 5; i++) model(1, 1'b0, BASE + 4 * (i == 1 ? 5 : i - 2), 4'h0, 32'h0, exp_d[i], exp_e[i]);
    @(negedge clk);
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        chk($sformatf("b2b%0d_rvalid", i - 1), {31'b0, rvalid[1]}, 32'd1);
        chk($sformatf("b2b%0d_rdata", i - 1), rdata[1], exp_d[i - 1]);
        chk($sformatf("b2b%0d_err", i - 1), {31'b0, err[1]}, {31'b0, exp_e[i - 1]});
      end
      if (i < 5) begin
        chk($sformatf("b2b%0d_gnt", i), {31'b0, gnt[1]}, 32'd1);
        req[1] = 1'b1; we[1] = i == 0; be[1] = i == 0 ? 4'hF : 4'($urandom);
        addr[1] = BASE + 4 * (i == 0 || i == 1 ? 5 : i - 2); wdata[1] = 32'hCAFE_F00D;
      end else req[1] = 1'b0;
      @(negedge clk);
    end
    chk("b2b_end_rvalid", {31'b0, rvalid[1]}, 32'd0);
    chk("b2b_store_visible", exp_d[1], 32'hCAFE_F00D);
    model(2, 1'b1, 32'h2008, 4'hF, 32'h5555_5555, er, ee);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h2008; be[2] = 4'hF; wdata[2] = 32'h5555_5555;
    @(posedge clk);
    #1 req[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rvalid[2]) seen++;
      @(negedge clk);
    end
    chk("midwait_no_rvalid", 32'(seen), 32'd0);
    chk_idle(2, "midwait_idle");
    txn(2, 1'b0, 32'h2008, 4'h1, 32'h0, "midwait_load");
    chk("midwait_load_const", rdata[2], 32'h5555_5555);
    for (int k = 0; k < 3; k++)
      for (int t = 0; t < 40; t++)
        txn(k, 1'($urandom), rand_addr(), 4'($urandom), $urandom, $sformatf("rnd%0d_%0d", k, t));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32_dmem_responder.md
Name: rv32_dmem_responder

Overview:
Data-memory responder at the far end of the core's load/store bus. It accepts requests from the rv32 core's LSU (the bus initiator), applies programmable wait states and returns read data or write acknowledgement with a single-cycle response strobe. It sits beside rv32_top as the backing data RAM for simulation and FPGA builds.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two).
BASE_ADDR, 32'h0000_2000, byte address of word 0.
WAIT_CYCLES, 1, idle cycles between acceptance and response (0..15).

Ports:
clk_sys_i  input  1  system clock, rising edge.
rst_n_i  input  1  reset, asynchronous assert, active-low.
req_i  input  1  request valid from core.
we_i  input  1  1 = store, 0 = load.
addr_i  input  32  byte address.
be_i  input  4  byte enables; bit n selects bits 8n+7:8n.
wdata_i  input  32  store data.
gnt_o  output  1  request accepted this cycle when req_i && gnt_o.
rvalid_o  output  1  one-cycle response strobe.
rdata_o  output  32  load data, valid with rvalid_o.
err_o  output  1  access fault, valid with rvalid_o.

Behaviour:
- One clock (clk_sys_i); reset rst_n_i is asynchronous, active-low. In reset: state IDLE, gnt_o=1, rvalid_o=0, rdata_o=0, err_o=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP. gnt_o = (state==IDLE) || (state==RESP), so back-to-back requests are accepted in the response cycle.
- Acceptance (req_i && gnt_o at a rising edge): latch we, fault flag and word index. Next state is WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise RESP.
- WAIT: decrement the counter each cycle. When counter==0, go to RESP on the next edge.
- Latency: response cycle = acceptance cycle + WAIT_CYCLES + 1.
- RESP: rvalid_o=1 for exactly one cycle. With no new acceptance, return to IDLE. With a new acceptance, go to WAIT or RESP as above.
- rdata_o/err_o are registered. They hold their value outside RESP and are cleared to 0 at reset. Writes return rdata_o=0.
- Address decode: offset = addr_i - BASE_ADDR, word index = offset[31:2], addr_i[1:0] ignored. Fault when addr_i < BASE_ADDR or offset >= 4*DEPTH_WORDS.
- Store: committed to the RAM on the acceptance edge, byte-masked by be_i. be_i==0 is a legal no-op and returns err_o=0. A faulting store writes nothing and returns err_o=1.
- Load: returns the full word regardless of be_i, sampled from the RAM on the edge entering RESP. It therefore sees every store accepted earlier, including one accepted in the immediately preceding cycle. A faulting load returns rdata_o=0, err_o=1.
- Reset mid-operation (WAIT or RESP): the pending response is dropped and no rvalid_o is issued. A store already accepted stays committed.
- req_i deasserted while in WAIT: no effect. Inputs are only sampled at acceptance.

Decomposition:
- Package rv32_bus_pkg: state enum (IDLE, WAIT, RESP); bus request struct (we, addr, be, wdata); word-width and byte-enable-width constants.
- Sub-module rv32_sp_ram_be: single-port, synchronous, byte-enable RAM with parameters DEPTH_WORDS and width 32, one read or write per cycle. The responder contains the FSM, decode and wait counter.

Test Plan:
- Reset then store: reset, store 32'hDEAD_BEEF to 32'h2000 with be=4'hF, WAIT_CYCLES=1 -> gnt_o=1 at acceptance; rvalid_o high exactly 2 cycles later, err_o=0.
- Load after store: load from 32'h2000 -> rdata_o=32'hDEAD_BEEF 2 cycles after acceptance.
- Byte-enable merge: store 32'h0000_00AA to 32'h2004 with be=4'hF, then store 32'h1122_3344 with be=4'b0100, then load -> rdata_o=32'h0022_00AA.
- Fault cases: load from 32'h1FFC and from 32'h2000+4*DEPTH_WORDS -> err_o=1, rdata_o=0. A later load of the adjacent in-range word shows unchanged contents.
- Zero-wait back-to-back (WAIT_CYCLES=0): req_i held high for 4 consecutive loads -> 4 consecutive rvalid_o pulses, each 1 cycle after its acceptance, gnt_o never low.
- Reset mid-WAIT (WAIT_CYCLES=3): store 32'h5555_5555 to 32'h2008, pulse rst_n_i low in cycle 2 -> no rvalid_o. A later load of 32'h2008 returns 32'h5555_5555.
